move_fifo: RTL and testbench

- Elastic buffer between move_generator and the downstream search/selection stage.
- move_generator emits move_t words with a valid strobe and no backpressure; this block absorbs bursts.
- Presents moves with a valid/ready handshake and tracks occupancy.
- A flush on every new board discards moves from the previous position; a sticky error flags overflow.

---
 rtl/move_fifo_pkg.sv | 13 +
 rtl/move_fifo_ram.sv | 28 ++
 rtl/move_fifo.sv | 101 ++++++++++
 tb/tb_move_fifo.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/move_fifo_pkg.sv
// Shared types between the move generator, move_fifo and the search stage.
package move_fifo_pkg;
   localparam int MOVE_FIFO_DEPTH = 64;

   typedef logic [3:0] piece_t;
   typedef piece_t [63:0] board_t;

   typedef struct packed {
      logic [5:0] from_sq;
      logic [5:0] to_sq;
      logic [3:0] flags;
   } move_t;
endpackage

// File: rtl/move_fifo_ram.sv
// Simple dual-port move storage with a registered read port.
// A write to the address being read returns the new word.
module move_fifo_ram
   import move_fifo_pkg::*;
#(
   parameter int DEPTH = MOVE_FIFO_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  move_t         wdata,
   input  logic [AW-1:0] raddr,
   output move_t         rdata
);
   move_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Write-through on collision so a push into an empty ring appears one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata <= '0;
      else     rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
   end
endmodule

// File: rtl/move_fifo.sv
// Elastic FWFT buffer for move_t words with flush, occupancy and sticky overflow.
// Define MOVE_FIFO_STATS_EN to add peak_count_out and drop_count_out.
module move_fifo
   import move_fifo_pkg::*;
#(
   parameter int DEPTH        = MOVE_FIFO_DEPTH,
   parameter int AFULL_MARGIN = 4
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       flush_in,
   input  move_t                      move_in,
   input  logic                       valid_in,
   output move_t                      move_out,
   output logic                       valid_out,
   input  logic                       ready_in,
   output logic [$clog2(DEPTH+1)-1:0] count_out,
   output logic                       almost_full_out,
   output logic                       overflow_out
`ifdef MOVE_FIFO_STATS_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] peak_count_out,
   output logic [15:0]                drop_count_out
`endif
);
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH+1);
   localparam int AF_TH = (DEPTH > AFULL_MARGIN) ? DEPTH - AFULL_MARGIN : 0;

   logic [AW-1:0] wr_ptr, rd_ptr, rd_next, raddr;
   logic [CW-1:0] count_next;
   logic          full, pop, push, drop;

   assign full = (count_out == CW'(DEPTH));
   assign pop  = valid_out && ready_in && !flush_in;
   assign push = valid_in && (!full || pop) && !flush_in;
   assign drop = valid_in && full && !pop && !flush_in;

   always_comb begin
      count_next = count_out;
      rd_next    = rd_ptr;
      if (pop) rd_next = rd_ptr + AW'(1);
      case ({push, pop})
         2'b10:   count_next = count_out + CW'(1);
         2'b01:   count_next = count_out - CW'(1);
         default: count_next = count_out;
      endcase
      raddr = flush_in ? '0 : rd_next;
   end

   // The RAM always prefetches the next head, so move_out tracks rd_ptr with no bubble.
   move_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk   (clk_in),
      .rst   (rst_in),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (move_in),
      .raddr (raddr),
      .rdata (move_out)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         count_out       <= '0;
         valid_out       <= 1'b0;
         almost_full_out <= 1'b0;
         overflow_out    <= 1'b0;
      end else if (flush_in) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         count_out       <= '0;
         valid_out       <= 1'b0;
         almost_full_out <= (AF_TH == 0);
         overflow_out    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr          <= rd_next;
         count_out       <= count_next;
         valid_out       <= (count_next != '0);
         almost_full_out <= (int'(count_next) >= AF_TH);
         if (drop) overflow_out <= 1'b1;
      end
   end

`ifdef MOVE_FIFO_STATS_EN
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         peak_count_out <= '0;
         drop_count_out <= '0;
      end else if (flush_in) begin
         peak_count_out <= '0;
         drop_count_out <= '0;
      end else begin
         if (count_next > peak_count_out) peak_count_out <= count_next;
         if (drop && (drop_count_out != 16'hFFFF)) drop_count_out <= drop_count_out + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_move_fifo.sv
// Directed bench for move_fifo: reset, FWFT latency, fill/overflow, full push+pop, flush, async reset.
module tb_move_fifo;
   import move_fifo_pkg::*;

   localparam int DEPTH = 64;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   move_t         move_in = '0;
   logic          valid_in = 1'b0;
   move_t         move_out;
   logic          valid_out;
   logic          ready_in = 1'b0;
   logic [CW-1:0] count_out;
   logic          almost_full;
   logic          overflow;
`ifdef MOVE_FIFO_STATS_EN
   logic [CW-1:0] peak_count;
   logic [15:0]   drop_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   move_fifo #(.DEPTH(DEPTH), .AFULL_MARGIN(4)) dut (
      .clk_in          (clk),
      .rst_in          (rst),
      .flush_in        (flush),
      .move_in         (move_in),
      .valid_in        (valid_in),
      .move_out        (move_out),
      .valid_out       (valid_out),
      .ready_in        (ready_in),
      .count_out       (count_out),
      .almost_full_out (almost_full),
      .overflow_out    (overflow)
`ifdef MOVE_FIFO_STATS_EN
      ,
      .peak_count_out  (peak_count),
      .drop_count_out  (drop_count)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #12 rst = 1'b0;
      step();

      // 1: reset then idle
      for (int i = 0; i < 10; i++) begin
         check("idle_count", 32'(count_out), 0);
         check("idle_valid", 32'(valid_out), 0);
         check("idle_ovf", 32'(overflow), 0);
         check("idle_af", 32'(almost_full), 0);
         step();
      end

      // 2: single push, one-cycle latency, stable while stalled
      move_in = 16'h0001; valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      check("lat_valid", 32'(valid_out), 1);
      check("lat_move", 32'(move_out), 32'h1);
      check("lat_count", 32'(count_out), 1);
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_move", 32'(move_out), 32'h1);
         check("stall_valid", 32'(valid_out), 1);
      end
      flush = 1'b1; step(); flush = 1'b0;
      check("flush1_count", 32'(count_out), 0);

      // 3: fill to full, one dropped push, drain in order
      for (int i = 0; i <= 64; i++) begin
         move_in = 16'(i); valid_in = 1'b1;
         step();
         if (i < 64) begin
            check("fill_count", 32'(count_out), 32'(i + 1));
            check("fill_af", 32'(almost_full), 32'((i + 1) >= 60));
            check("fill_ovf", 32'(overflow), 0);
         end
      end
      valid_in = 1'b0;
      check("full_count", 32'(count_out), 64);
      check("full_ovf", 32'(overflow), 1);
      check("full_af", 32'(almost_full), 1);
`ifdef MOVE_FIFO_STATS_EN
      check("peak64", 32'(peak_count), 64);
      check("drop1", 32'(drop_count), 1);
`endif
      ready_in = 1'b1;
      for (int j = 0; j < 64; j++) begin
         check("drain_valid", 32'(valid_out), 1);
         check("drain_move", 32'(move_out), 32'(j));
         step();
      end
      ready_in = 1'b0;
      check("drained_valid", 32'(valid_out), 0);
      check("drained_count", 32'(count_out), 0);
      check("drained_af", 32'(almost_full), 0);
      check("sticky_ovf", 32'(overflow), 1);

      // 4: push and pop together while full
      flush = 1'b1; step(); flush = 1'b0;
      check("flush2_ovf", 32'(overflow), 0);
      for (int i = 0; i < 64; i++) begin
         move_in = 16'(16'h0100 + i); valid_in = 1'b1;
         step();
      end
      check("refill_count", 32'(count_out), 64);
      check("refill_head", 32'(move_out), 32'h100);
      move_in = 16'h01FF; ready_in = 1'b1;
      step();
      valid_in = 1'b0;
      check("pp_count", 32'(count_out), 64);
      check("pp_ovf", 32'(overflow), 0);
      check("pp_head", 32'(move_out), 32'h101);
      for (int j = 0; j < 64; j++) begin
         check("pp_drain_valid", 32'(valid_out), 1);
         check("pp_drain_move", 32'(move_out), (j == 63) ? 32'h1FF : 32'(16'h0101 + j));
         step();
      end
      ready_in = 1'b0;
      check("pp_empty", 32'(valid_out), 0);

      // 5: flush beats a same-cycle push and pop
      for (int i = 0; i < 10; i++) begin
         move_in = 16'(16'h0200 + i); valid_in = 1'b1;
         step();
      end
      check("pre_flush_count", 32'(count_out), 10);
      flush = 1'b1; move_in = 16'h02AA; ready_in = 1'b1;
      step();
      flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
      check("flush_count", 32'(count_out), 0);
      check("flush_valid", 32'(valid_out), 0);
      check("flush_ovf", 32'(overflow), 0);
      step(); step();
      check("flush_absent_count", 32'(count_out), 0);
      check("flush_absent_valid", 32'(valid_out), 0);
      move_in = 16'h02BB; valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      check("post_flush_move", 32'(move_out), 32'h2BB);
      check("post_flush_count", 32'(count_out), 1);

      // 6: asynchronous reset mid-burst
      flush = 1'b1; step(); flush = 1'b0;
      for (int i = 0; i < 20; i++) begin
         move_in = 16'(16'h0300 + i); valid_in = 1'b1;
         step();
      end
      check("burst_count", 32'(count_out), 20);
      #2 rst = 1'b1;
      #1;
      check("arst_count", 32'(count_out), 0);
      check("arst_valid", 32'(valid_out), 0);
      check("arst_move", 32'(move_out), 0);
      check("arst_af", 32'(almost_full), 0);
      check("arst_ovf", 32'(overflow), 0);
`ifdef MOVE_FIFO_STATS_EN
      check("arst_peak", 32'(peak_count), 0);
      check("arst_drop", 32'(drop_count), 0);
`endif
      valid_in = 1'b0;
      #3 rst = 1'b0;
      step();
      check("post_rst_count", 32'(count_out), 0);
      check("post_rst_valid", 32'(valid_out), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
